alu_operand_loader: RTL and testbench

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/key_debounce.sv | 53 +++++
 rtl/alu_operand_loader.sv | 97 +++++++++
 tb/tb_alu_operand_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the operand-loader state encoding.
// ALU_LOADER_SIGN_EXT_EN selects sign extension of switch operands (zero extension otherwise).
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  aluop_t;

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    ISSUE  = 2'd3
  } loader_state_t;

  localparam int KEY_ENTER = 0;
  localparam int KEY_ABORT = 3;

  function automatic word_t ext_sw(input logic [15:0] sw);
`ifdef ALU_LOADER_SIGN_EXT_EN
    return {{16{sw[15]}}, sw};
`else
    return {16'h0000, sw};
`endif
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, debounce counter and a one-cycle pulse
// on each accepted press (debounced 1->0 edge).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter holds how many cycles the synchronized level has disagreed so far;
  // the level flips on the DEBOUNCE_CYCLES-th consecutive disagreement.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Loads operand A, operand B and the opcode from switches on debounced ENTER presses,
// then offers them to the ALU with a valid/ready handshake. ALU_LOADER_SIGN_EXT_EN: sign-extend operands.
module alu_operand_loader
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [15:0] sw,
  input  logic [3:0]  key_n,
  input  logic        out_ready,
  output logic        out_valid,
  output word_t       porta,
  output word_t       portb,
  output aluop_t      aluop,
  output logic [1:0]  state_dbg,
  output logic [7:0]  xfer_cnt
);

  logic enter_p, abort_p;
  logic unused_keys;

  assign unused_keys = ^key_n[2:1];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .CLK   (CLK),
    .nRST  (nRST),
    .key_n (key_n[KEY_ENTER]),
    .press (enter_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_abort (
    .CLK   (CLK),
    .nRST  (nRST),
    .key_n (key_n[KEY_ABORT]),
    .press (abort_p)
  );

  loader_state_t state_q, state_d;
  word_t         porta_q, porta_d, portb_q, portb_d;
  aluop_t        aluop_q, aluop_d;
  logic [7:0]    xfer_cnt_q, xfer_cnt_d;
  logic          out_valid_q, out_valid_d;

  always_comb begin
    state_d    = state_q;
    porta_d    = porta_q;
    portb_d    = portb_q;
    aluop_d    = aluop_q;
    xfer_cnt_d = xfer_cnt_q;
    if (state_q == ISSUE) begin
      // A ready cycle completes the transfer even when ABORT arrives with it.
      if (out_ready) begin
        xfer_cnt_d = xfer_cnt_q + 8'd1;
        state_d    = GET_A;
      end else if (abort_p) begin
        state_d = GET_A;
      end
    end else if (abort_p) begin
      state_d = GET_A;
    end else if (enter_p) begin
      case (state_q)
        GET_A:   begin porta_d = ext_sw(sw); state_d = GET_B;  end
        GET_B:   begin portb_d = ext_sw(sw); state_d = GET_OP; end
        default: begin aluop_d = sw[3:0];    state_d = ISSUE;  end
      endcase
    end
    out_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= GET_A;
      porta_q     <= '0;
      portb_q     <= '0;
      aluop_q     <= '0;
      xfer_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      porta_q     <= porta_d;
      portb_q     <= portb_d;
      aluop_q     <= aluop_d;
      xfer_cnt_q  <= xfer_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign porta     = porta_q;
  assign portb     = portb_q;
  assign aluop     = aluop_q;
  assign state_dbg = state_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: directed scenarios plus random key/switch/ready traffic,
// checked every cycle against a window-based key model and an operation-level loader model.
module tb_alu_operand_loader;

  localparam int N = 4;

  logic        CLK;
  logic        nRST;
  logic [15:0] sw;
  logic [3:0]  key_n;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] porta, portb;
  logic [3:0]  aluop;
  logic [1:0]  state_dbg;
  logic [7:0]  xfer_cnt;

  alu_operand_loader #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .sw        (sw),
    .key_n     (key_n),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .porta     (porta),
    .portb     (portb),
    .aluop     (aluop),
    .state_dbg (state_dbg),
    .xfer_cnt  (xfer_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expect_ext(input logic [15:0] v);
`ifdef ALU_LOADER_SIGN_EXT_EN
    return (v[15] ? 32'hFFFF0000 : 32'h0) | 32'(v);
`else
    return 32'(v);
`endif
  endfunction

  // Reference model: a key's debounced level flips when the last N synchronized
  // samples (key samples from 2..N+1 edges ago) all disagree with it.
  int          m_stage;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [7:0]  m_cnt;
  logic [15:0] m_hist [2];
  logic        m_lvl  [2];
  logic        m_pulse[2];

  task automatic model_reset();
    m_stage = 0; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      m_hist[k] = '1; m_lvl[k] = 1'b1; m_pulse[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] win;
    logic         key;
    if (m_stage == 3) begin
      if (out_ready) begin m_cnt = m_cnt + 8'd1; m_stage = 0; end
      else if (m_pulse[1]) m_stage = 0;
    end else if (m_pulse[1]) begin
      m_stage = 0;
    end else if (m_pulse[0]) begin
      if (m_stage == 0) m_a = expect_ext(sw);
      else if (m_stage == 1) m_b = expect_ext(sw);
      else m_op = sw[3:0];
      m_stage = m_stage + 1;
    end
    for (int k = 0; k < 2; k++) begin
      key = (k == 0) ? key_n[0] : key_n[3];
      m_hist[k] = {m_hist[k][14:0], key};
      win = m_hist[k][N+1:2];
      m_pulse[k] = 1'b0;
      if (m_lvl[k] && win == '0) begin
        m_lvl[k] = 1'b0; m_pulse[k] = 1'b1;
      end else if (!m_lvl[k] && &win) begin
        m_lvl[k] = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge nRST);
      if (!nRST) model_reset();
      else model_step();
    end
  end

  logic [7:0] prev_cnt = 8'd0;
  always @(negedge CLK) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_stage == 3});
    chk("state_dbg", {30'd0, state_dbg}, 32'(m_stage));
    chk("porta", porta, m_a);
    chk("portb", portb, m_b);
    chk("aluop", {28'd0, aluop}, {28'd0, m_op});
    chk("xfer_cnt", {24'd0, xfer_cnt}, {24'd0, m_cnt});
    if (nRST && xfer_cnt != prev_cnt)
      $display("xfer #%0d: porta=0x%08h portb=0x%08h aluop=0x%h", xfer_cnt, porta, portb, aluop);
    prev_cnt = xfer_cnt;
  end

  task automatic press(input logic [3:0] mask);
    key_n = 4'hF & ~mask;
    repeat (N + 5) @(negedge CLK);
    key_n = 4'hF;
    repeat (N + 5) @(negedge CLK);
  endtask

  task automatic enter_val(input logic [15:0] v);
    sw = v;
    press(4'b0001);
  endtask

  task automatic do_xfer();
    enter_val(16'($urandom));
    enter_val(16'($urandom));
    enter_val(16'($urandom));
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; sw = 16'h0; key_n = 4'hF; out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_porta", porta, 32'd0);
    chk("rst_cnt", {24'd0, xfer_cnt}, 32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Short glitch, then a held press with pulse timing.
    key_n[0] = 1'b0;
    repeat (N - 1) @(negedge CLK);
    key_n = 4'hF;
    repeat (2 * N + 4) @(negedge CLK);
    chk("s3_glitch", {30'd0, state_dbg}, 32'd0);
    sw = 16'h0012;
    key_n[0] = 1'b0;
    repeat (N + 2) @(posedge CLK);
    @(negedge CLK);
    chk("s3_before", {30'd0, state_dbg}, 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("s3_after", {30'd0, state_dbg}, 32'd1);
    repeat (2) @(negedge CLK);
    key_n = 4'hF;
    repeat (N + 5) @(negedge CLK);
    chk("s3_one_advance", {30'd0, state_dbg}, 32'd1);

    enter_val(16'h0034);
    enter_val(16'h0002);
    chk("s1_valid", {31'd0, out_valid}, 32'd1);
    chk("s1_porta", porta, 32'h00000012);
    chk("s1_portb", portb, 32'h00000034);
    chk("s1_aluop", {28'd0, aluop}, 32'h2);
    chk("s1_state", {30'd0, state_dbg}, 32'd3);

    repeat (10) @(negedge CLK);
    chk("s2_held_valid", {31'd0, out_valid}, 32'd1);
    chk("s2_held_porta", porta, 32'h00000012);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    chk("s2_cnt", {24'd0, xfer_cnt}, 32'd1);
    chk("s2_state", {30'd0, state_dbg}, 32'd0);

    enter_val(16'h8001);
`ifdef ALU_LOADER_SIGN_EXT_EN
    chk("s4_porta", porta, 32'hFFFF8001);
`else
    chk("s4_porta", porta, 32'h00008001);
`endif

    sw = 16'h5555;
    press(4'b1001);
    chk("s5_state", {30'd0, state_dbg}, 32'd0);
    chk("s5_portb", portb, 32'h00000034);

    enter_val(16'h0007);
    enter_val(16'h0009);
    enter_val(16'h0004);
    key_n[3] = 1'b0;
    repeat (N + 2) @(posedge CLK);
    @(negedge CLK);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    repeat (2) @(negedge CLK);
    key_n = 4'hF;
    repeat (N + 5) @(negedge CLK);
    chk("s5_abort_ready_cnt", {24'd0, xfer_cnt}, 32'd2);
    chk("s5_abort_ready_state", {30'd0, state_dbg}, 32'd0);

    for (int i = 0; i < 254; i++) do_xfer();
    chk("s6_wrap", {24'd0, xfer_cnt}, 32'd0);

    enter_val(16'h0101);
    enter_val(16'h0202);
    enter_val(16'h0003);
    chk("s6_in_issue", {31'd0, out_valid}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("s6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("s6_rst_state", {30'd0, state_dbg}, 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 400; i++) begin
      sw = 16'($urandom);
      out_ready = ($urandom_range(0, 3) == 0);
      key_n[0] = 1'($urandom_range(0, 1));
      key_n[2:1] = 2'($urandom);
      key_n[3] = ($urandom_range(0, 5) != 0);
      repeat ($urandom_range(1, 12)) @(negedge CLK);
    end
    key_n = 4'hF;
    repeat (2 * N + 4) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
